dma_copier: RTL

DMA_COPIER -- requirements
Module: dma_copier

---
 rtl/dma_copier.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/dma_copier.sv
// -----------------------------------------------------------------------------
// dma_copier -- single-channel memory-to-memory word copier (bus initiator)
//
// Copies `len` 32-bit words from `src` to `dst`, one bus transaction in flight
// at a time: read a word, write it back out, advance both addresses by 4,
// repeat. Against a responder that answers one cycle after req the loop runs
// at four cycles per word (REQ, WAIT, REQ, WAIT).
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start, src, dst,    command; sampled only while idle
//   len
//   busy                high whenever the engine is not idle
//   done                one-cycle pulse on successful completion
//   err, err_code,      sticky error status (1 = bus fault, 2 = timeout) and
//   err_addr            the bus address of the transaction that failed
//   addr, w_rb, acc,    registered bus request (w_rb: 1 write, 0 read)
//   wdata, req
//   rdata, resp, fault  bus response
// -----------------------------------------------------------------------------
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module dma_copier #(
    parameter int TIMEOUT = 255,   // bus-wait cycles tolerated, 1..255
    parameter int AW      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [AW-1:0]             src,
    input  logic [AW-1:0]             dst,
    input  logic [15:0]               len,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [1:0]                err_code,
    output logic [AW-1:0]             err_addr,
    output logic [AW-1:0]             addr,
    output logic                      w_rb,
    output logic [`BUS_ACC_WIDTH-1:0] acc,
    output logic [`BUS_WIDTH-1:0]     wdata,
    input  logic [`BUS_WIDTH-1:0]     rdata,
    output logic                      req,
    input  logic                      resp,
    input  logic                      fault
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_FAULT   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [7:0] WAIT_LAST   = 8'(TIMEOUT - 1);

    state_t                  state_q,    state_d;
    logic [AW-1:0]           src_q,      src_d;
    logic [AW-1:0]           dst_q,      dst_d;
    logic [15:0]             rem_q,      rem_d;
    logic [7:0]              wait_q,     wait_d;
    logic [AW-1:0]           addr_q,     addr_d;
    logic                    w_rb_q,     w_rb_d;
    logic                    req_q,      req_d;
    logic [`BUS_WIDTH-1:0]   wdata_q,    wdata_d;
    logic                    err_q,      err_d;
    logic [1:0]              err_code_q, err_code_d;
    logic [AW-1:0]           err_addr_q, err_addr_d;

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        rem_d      = rem_q;
        wait_d     = wait_q;
        addr_d     = addr_q;
        w_rb_d     = 1'b0;
        req_d      = 1'b0;
        wdata_d    = wdata_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        err_addr_d = err_addr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != 16'd0) begin
                        src_d      = src;
                        dst_d      = dst;
                        rem_d      = len;
                        err_d      = 1'b0;
                        err_code_d = ERR_NONE;
                        state_d    = RD_REQ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            RD_REQ: begin
                // addr_q still holds the address being presented this cycle
                if (fault) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_FAULT;
                    err_addr_d = addr_q;
                    state_d    = IDLE;
                end else begin
                    wait_d  = 8'd0;
                    state_d = RD_WAIT;
                end
            end

            RD_WAIT: begin
                if (resp) begin
                    // The write-data register doubles as the read capture
                    // register: it is what WR_REQ drives onto the bus.
                    wdata_d = rdata;
                    state_d = WR_REQ;
                end else if (wait_q == WAIT_LAST) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    err_addr_d = addr_q;
                    state_d    = IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            WR_REQ: begin
                if (fault) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_FAULT;
                    err_addr_d = addr_q;
                    state_d    = IDLE;
                end else begin
                    wait_d  = 8'd0;
                    state_d = WR_WAIT;
                end
            end

            WR_WAIT: begin
                if (resp) begin
                    rem_d   = rem_q - 16'd1;
                    src_d   = src_q + AW'(4);
                    dst_d   = dst_q + AW'(4);
                    state_d = (rem_q == 16'd1) ? DONE : RD_REQ;
                end else if (wait_q == WAIT_LAST) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    err_addr_d = addr_q;
                    state_d    = IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Bus request outputs are registered from the next state so that
        // req/addr/w_rb are valid for exactly the cycle spent in a REQ state.
        // addr is left holding afterwards so the failing address is on hand.
        if (state_d == RD_REQ) begin
            req_d  = 1'b1;
            w_rb_d = 1'b0;
            addr_d = src_d;
        end else if (state_d == WR_REQ) begin
            req_d  = 1'b1;
            w_rb_d = 1'b1;
            addr_d = dst_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            rem_q      <= '0;
            wait_q     <= '0;
            addr_q     <= '0;
            w_rb_q     <= 1'b0;
            req_q      <= 1'b0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            rem_q      <= rem_d;
            wait_q     <= wait_d;
            addr_q     <= addr_d;
            w_rb_q     <= w_rb_d;
            req_q      <= req_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign err      = err_q;
    assign err_code = err_code_q;
    assign err_addr = err_addr_q;
    assign addr     = addr_q;
    assign w_rb     = w_rb_q;
    assign req      = req_q;
    assign wdata    = wdata_q;
    assign acc      = `BUS_ACC_4B;

endmodule
